ntt_iter_engine: RTL and testbench

NTT_ITER_ENGINE -- requirements
Module: ntt_iter_engine

---
 rtl/ntt_pkg.sv | 47 ++++
 rtl/ntt_bf_unit.sv | 73 +++++++
 rtl/ntt_iter_engine.sv | 275 +++++++++++++++++++++++++++
 tb/tb_ntt_iter_engine.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared types and helpers for the iterative NTT engine: FSM state encoding,
// log2(N)-derived width constants and the bit-reversal permutation.
package ntt_pkg;

  // FSM states of the engine
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_COMPUTE = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_UNLOAD  = 3'd4
  } ntt_state_e;

  // Default transform size and coefficient width
  localparam int NTT_N_DEF = 8;
  localparam int NTT_W_DEF = 8;

  // Widths derived from log2(N) for the default size
  localparam int NTT_LOGN_DEF    = $clog2(NTT_N_DEF);
  localparam int NTT_STAGE_W_DEF = (NTT_LOGN_DEF > 1) ? $clog2(NTT_LOGN_DEF) : 1;

  // Number of butterfly stages (also the element index width) for size n
  function automatic int ntt_logn(input int n);
    return $clog2(n);
  endfunction

  // Width of the stage counter for size n (at least one bit)
  function automatic int ntt_stage_w(input int n);
    int logn;
    logn = $clog2(n);
    return (logn > 1) ? $clog2(logn) : 1;
  endfunction

  // Reverse the low nbits of v; upper result bits are zero
  function automatic logic [31:0] bitrev(input logic [31:0] v, input int nbits);
    logic [31:0] r;
    logic [31:0] t;
    r = 32'd0;
    t = v;
    for (int j = 0; j < 32; j++) begin
      r = (j < nbits) ? {r[30:0], t[0]} : r;
      t = (j < nbits) ? (t >> 1) : t;
    end
    return r;
  endfunction

endpackage

// File: rtl/ntt_bf_unit.sv
// Two-stage pipelined modular butterfly: lo = (a + w*b) mod q,
// hi = (a - w*b) mod q. Inputs a and b must already be reduced below q.
module ntt_bf_unit #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] w_i,
  input  logic [W-1:0] q_i,
  output logic [W-1:0] lo_o,
  output logic [W-1:0] hi_o
);

  logic [2*W-1:0] prod_s;
  logic [W-1:0]   pm_s;
  logic [W-1:0]   a_q, pm_q, q_q;
  logic [2*W-1:0] sum_s;
  logic [2*W-1:0] dif_s;
  logic [W-1:0]   lo_d, hi_d;
  logic [W-1:0]   lo_q, hi_q;

  // Stage 1: full-width product of twiddle and b, reduced mod q
  always_comb begin
    prod_s = (2*W)'(w_i) * (2*W)'(b_i);
    pm_s   = W'(prod_s % (2*W)'(q_i));
  end

  // Stage 1 pipeline register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= {W{1'b0}};
      pm_q <= {W{1'b0}};
      q_q  <= {W{1'b0}};
    end else begin
      a_q  <= a_i;
      pm_q <= pm_s;
      q_q  <= q_i;
    end
  end

  // Stage 2: modular add and subtract with single conditional correction
  always_comb begin
    sum_s = (2*W)'(a_q) + (2*W)'(pm_q);
    if (sum_s >= (2*W)'(q_q)) begin
      lo_d = W'(sum_s - (2*W)'(q_q));
    end else begin
      lo_d = W'(sum_s);
    end
    if (a_q >= pm_q) begin
      dif_s = (2*W)'(a_q) - (2*W)'(pm_q);
    end else begin
      dif_s = (2*W)'(a_q) + (2*W)'(q_q) - (2*W)'(pm_q);
    end
    hi_d = W'(dif_s);
  end

  // Stage 2 output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_q <= {W{1'b0}};
      hi_q <= {W{1'b0}};
    end else begin
      lo_q <= lo_d;
      hi_q <= hi_d;
    end
  end

  assign lo_o = lo_q;
  assign hi_o = hi_q;

endmodule

// File: rtl/ntt_iter_engine.sv
// Iterative in-place radix-2 DIT number-theoretic transform. Coefficients are
// streamed in natural order into a bit-reversed buffer, transformed one
// butterfly per cycle, and streamed back out in natural order.
module ntt_iter_engine
  import ntt_pkg::*;
#(
  parameter int N = NTT_N_DEF,
  parameter int W = NTT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [W-1:0]          mod,
  input  logic [N/2-1:0][W-1:0] omegas,
  input  logic [W-1:0]          in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [W-1:0]          out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy
);

  localparam int LOGN = ntt_logn(N);
  localparam int CW   = LOGN;
  localparam int SW   = ntt_stage_w(N);
  localparam int HALF = N / 2;

  ntt_state_e state_q, state_d;

  logic [CW-1:0]          cnt_q, cnt_d;
  logic [SW-1:0]          stage_q, stage_d;
  logic                   drain_q, drain_d;
  logic [W-1:0]           mod_q, mod_d;
  logic [HALF-1:0][W-1:0] omg_q, omg_d;
  logic [W-1:0]           buf_q [N];
  logic [W-1:0]           buf_d [N];
  logic [W-1:0]           out_data_q, out_data_d;
  logic                   out_valid_q, out_valid_d;
  logic                   out_last_q, out_last_d;

  // Butterfly write-back pipeline, aligned with the 2-cycle unit latency
  logic                   v1_q, v2_q;
  logic [CW-1:0]          i1_q, j1_q, i2_q, j2_q;

  logic                   in_ready_s, busy_s;
  logic                   accept_in_s, accept_out_s;
  logic                   issue_s, last_stage_s;
  logic [W-1:0]           q_in_s, red_s;
  logic [CW-1:0]          load_idx_s;
  logic [CW-1:0]          h_s, k_s, i_s, j_s, tw_idx_s;
  logic [W-1:0]           a_s, b_s, w_s;
  logic [W-1:0]           lo_s, hi_s;

  // Handshakes, input reduction and butterfly address generation
  always_comb begin
    accept_in_s  = in_valid && in_ready_s;
    accept_out_s = out_valid_q && out_ready;
    issue_s      = (state_q == ST_COMPUTE);
    last_stage_s = (stage_q == SW'(LOGN - 1));
    // The first beat arrives before the modulus is captured
    q_in_s       = (state_q == ST_IDLE) ? mod : mod_q;
    red_s        = in_data % q_in_s;
    load_idx_s   = CW'(bitrev(32'(cnt_q), LOGN));
    h_s          = CW'(1) << stage_q;
    k_s          = cnt_q & (h_s - CW'(1));
    i_s          = (((cnt_q >> stage_q) << stage_q) << 1) + k_s;
    j_s          = i_s + h_s;
    tw_idx_s     = k_s << (SW'(LOGN - 1) - stage_q);
    a_s          = buf_q[i_s];
    b_s          = buf_q[j_s];
    w_s          = {W{1'b0}};
    for (int t = 0; t < HALF; t++) begin
      w_s = (tw_idx_s == CW'(t)) ? omg_q[t] : w_s;
    end
  end

  ntt_bf_unit #(.W(W)) u_bf (
    .clk  (clk),
    .rst_n(rst_n),
    .a_i  (a_s),
    .b_i  (b_s),
    .w_i  (w_s),
    .q_i  (mod_q),
    .lo_o (lo_s),
    .hi_o (hi_s)
  );

  // Next buffer contents: load writes and butterfly write-back never overlap
  always_comb begin
    for (int t = 0; t < N; t++) begin
      buf_d[t] = buf_q[t];
    end
    if (accept_in_s) begin
      buf_d[load_idx_s] = red_s;
    end else if (v2_q) begin
      buf_d[i2_q] = lo_s;
      buf_d[j2_q] = hi_s;
    end else begin
      buf_d[0] = buf_q[0];
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_in_s) state_d = ST_LOAD;
        else             state_d = ST_IDLE;
      end
      ST_LOAD: begin
        if (accept_in_s && (cnt_q == CW'(N - 1))) state_d = ST_COMPUTE;
        else                                      state_d = ST_LOAD;
      end
      ST_COMPUTE: begin
        if (cnt_q == CW'(HALF - 1)) state_d = ST_DRAIN;
        else                        state_d = ST_COMPUTE;
      end
      ST_DRAIN: begin
        if (drain_q && last_stage_s) state_d = ST_UNLOAD;
        else if (drain_q)            state_d = ST_COMPUTE;
        else                         state_d = ST_DRAIN;
      end
      ST_UNLOAD: begin
        if (accept_out_s && out_last_q) state_d = ST_IDLE;
        else                            state_d = ST_UNLOAD;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    in_ready_s = (state_q == ST_IDLE) || (state_q == ST_LOAD);
    busy_s     = (state_q != ST_IDLE);
  end

  // Counters, operand capture and registered output stream
  always_comb begin
    cnt_d       = cnt_q;
    stage_d     = stage_q;
    drain_d     = drain_q;
    mod_d       = mod_q;
    omg_d       = omg_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    case (state_q)
      ST_IDLE: begin
        stage_d = SW'(0);
        drain_d = 1'b0;
        if (accept_in_s) begin
          mod_d = mod;
          omg_d = omegas;
          cnt_d = CW'(1);
        end else begin
          cnt_d = CW'(0);
        end
      end
      ST_LOAD: begin
        if (accept_in_s && (cnt_q == CW'(N - 1))) cnt_d = CW'(0);
        else if (accept_in_s)                     cnt_d = cnt_q + CW'(1);
        else                                      cnt_d = cnt_q;
      end
      ST_COMPUTE: begin
        if (cnt_q == CW'(HALF - 1)) begin
          cnt_d   = CW'(0);
          drain_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DRAIN: begin
        if (drain_q && last_stage_s) begin
          drain_d     = 1'b0;
          stage_d     = SW'(0);
          cnt_d       = CW'(0);
          out_valid_d = 1'b1;
          // buf_d forwards a write landing on this same edge
          out_data_d  = buf_d[0];
          out_last_d  = 1'b0;
        end else if (drain_q) begin
          drain_d = 1'b0;
          stage_d = stage_q + SW'(1);
        end else begin
          drain_d = 1'b1;
        end
      end
      ST_UNLOAD: begin
        if (accept_out_s && out_last_q) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          cnt_d       = CW'(0);
        end else if (accept_out_s) begin
          cnt_d      = cnt_q + CW'(1);
          out_data_d = buf_q[cnt_q + CW'(1)];
          out_last_d = ((cnt_q + CW'(1)) == CW'(N - 1));
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        cnt_d       = CW'(0);
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= CW'(0);
      stage_q     <= SW'(0);
      drain_q     <= 1'b0;
      mod_q       <= {W{1'b0}};
      omg_q       <= {(HALF*W){1'b0}};
      out_data_q  <= {W{1'b0}};
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      stage_q     <= stage_d;
      drain_q     <= drain_d;
      mod_q       <= mod_d;
      omg_q       <= omg_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  // Write-back index pipeline; reset drops any butterfly in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      i1_q <= CW'(0);
      j1_q <= CW'(0);
      i2_q <= CW'(0);
      j2_q <= CW'(0);
    end else begin
      v1_q <= issue_s;
      v2_q <= v1_q;
      i1_q <= i_s;
      j1_q <= j_s;
      i2_q <= i1_q;
      j2_q <= j1_q;
    end
  end

  // Coefficient buffer; contents are fully rewritten by every load
  always_ff @(posedge clk) begin
    for (int t = 0; t < N; t++) begin
      buf_q[t] <= buf_d[t];
    end
  end

  assign in_ready  = in_ready_s;
  assign busy      = busy_s;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_ntt_iter_engine.sv
// Directed bench for ntt_iter_engine (N=8 main instance, N=4 side instance).
module tb_ntt_iter_engine;

  typedef logic [7:0] vec_t [8];

  logic            clk = 1'b0;
  logic            rst_n;
  logic [7:0]      mod;
  logic [3:0][7:0] omegas;
  logic [7:0]      in_data;
  logic            in_valid;
  logic            in_ready;
  logic [7:0]      out_data;
  logic            out_valid;
  logic            out_ready;
  logic            out_last;
  logic            busy;

  logic [7:0]      mod4;
  logic [1:0][7:0] omegas4;
  logic [7:0]      in_data4;
  logic            in_valid4;
  logic            in_ready4;
  logic [7:0]      out_data4;
  logic            out_valid4;
  logic            out_ready4;
  logic            out_last4;
  logic            busy4;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  ntt_iter_engine #(.N(8), .W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .mod(mod), .omegas(omegas),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy)
  );

  ntt_iter_engine #(.N(4), .W(8)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .mod(mod4), .omegas(omegas4),
    .in_data(in_data4), .in_valid(in_valid4), .in_ready(in_ready4),
    .out_data(out_data4), .out_valid(out_valid4), .out_ready(out_ready4),
    .out_last(out_last4), .busy(busy4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_tw17();
    mod    = 8'd17;
    omegas = {8'd8, 8'd4, 8'd2, 8'd1};
  endtask

  // Stream one vector in; returns #1 after the edge that accepts the last beat
  task automatic send_vec(input vec_t v, input int gap, input string name);
    for (int n = 0; n < 8; n++) begin
      int   guard;
      logic acc;
      guard    = 0;
      in_data  = v[n];
      in_valid = 1'b1;
      do begin
        acc = in_ready;
        tick();
        guard++;
      end while (!acc && guard < 200);
      if (!acc) begin
        chk_cnt++;
        $display("FAIL %s send timeout: beat %0d never accepted", name, n);
      end
      in_valid = 1'b0;
      if (n < 7) begin
        for (int g = 0; g < gap; g++) tick();
      end
    end
  endtask

  // Wait from the COMPUTE entry edge for out_valid; checks latency and in_ready low
  task automatic wait_out(input string name);
    int cyc;
    bit rdy_seen;
    cyc      = 0;
    rdy_seen = 1'b0;
    while (!out_valid && cyc < 200) begin
      if (in_ready !== 1'b0) rdy_seen = 1'b1;
      tick();
      cyc++;
    end
    chk_cnt++;
    if (cyc !== 18) $display("FAIL %s latency: got %0d cycles, expected 18", name, cyc);
    else pass_cnt++;
    chk_cnt++;
    if (rdy_seen !== 1'b0) $display("FAIL %s in_ready during compute: got 1, expected 0", name);
    else pass_cnt++;
    chk_cnt++;
    if (busy !== 1'b1) $display("FAIL %s busy at unload: got %b, expected 1", name, busy);
    else pass_cnt++;
  endtask

  // Drain one result vector, optionally with random back-pressure
  task automatic recv_vec(input vec_t exp, input bit rnd, input string name);
    for (int n = 0; n < 8; n++) begin
      int         guard;
      bit         done;
      logic [7:0] hd;
      logic       hl;
      guard = 0;
      done  = 1'b0;
      while (!done && guard < 200) begin
        out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (out_valid && out_ready) begin
          chk_cnt++;
          if (out_data !== exp[n]) $display("FAIL %s data[%0d]: got %0d, expected %0d", name, n, out_data, exp[n]);
          else pass_cnt++;
          chk_cnt++;
          if (out_last !== (n == 7)) $display("FAIL %s last[%0d]: got %b, expected %b", name, n, out_last, (n == 7));
          else pass_cnt++;
          chk_cnt++;
          if (in_ready !== 1'b0) $display("FAIL %s in_ready in unload[%0d]: got %b, expected 0", name, n, in_ready);
          else pass_cnt++;
          done = 1'b1;
          tick();
        end else if (out_valid) begin
          hd = out_data;
          hl = out_last;
          tick();
          guard++;
          chk_cnt++;
          if (out_valid !== 1'b1 || out_data !== hd || out_last !== hl)
            $display("FAIL %s stall hold[%0d]: got %0d/%b, expected %0d/%b", name, n, out_data, out_last, hd, hl);
          else pass_cnt++;
        end else begin
          tick();
          guard++;
        end
      end
      if (!done) begin
        chk_cnt++;
        $display("FAIL %s recv timeout at element %0d", name, n);
      end
    end
    out_ready = 1'b0;
    chk_cnt++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL %s return to idle: got rdy=%b busy=%b vld=%b, expected 1/0/0", name, in_ready, busy, out_valid);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    chk_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 || out_data !== 8'd0)
      $display("FAIL reset state: got rdy=%b vld=%b last=%b busy=%b data=%0d, expected 1/0/0/0/0",
               in_ready, out_valid, out_last, busy, out_data);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_impulse(input vec_t vin, input vec_t vexp);
    send_vec(vin, 0, "impulse");
    wait_out("impulse");
    recv_vec(vexp, 1'b0, "impulse");
  endtask

  task automatic test_all_ones(input vec_t vin, input vec_t vexp);
    send_vec(vin, 0, "ones");
    wait_out("ones");
    recv_vec(vexp, 1'b1, "ones");
  endtask

  task automatic test_mod_change(input vec_t vin, input vec_t vexp);
    send_vec(vin, 3, "modchg");
    mod    = 8'd5;
    omegas = {8'd3, 8'd3, 8'd3, 8'd3};
    wait_out("modchg");
    recv_vec(vexp, 1'b0, "modchg");
    set_tw17();
  endtask

  task automatic test_reset_mid(input vec_t vin, input vec_t vexp);
    send_vec(vin, 0, "rstmid");
    for (int c = 0; c < 7; c++) tick();
    chk_cnt++;
    if (busy !== 1'b1) $display("FAIL rstmid busy before reset: got %b, expected 1", busy);
    else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    chk_cnt++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL rstmid immediate: got busy=%b vld=%b rdy=%b, expected 0/0/1", busy, out_valid, in_ready);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    send_vec(vin, 0, "rstmid2");
    wait_out("rstmid2");
    recv_vec(vexp, 1'b0, "rstmid2");
  endtask

  task automatic test_back_to_back(input vec_t va, input vec_t ea, input vec_t vb, input vec_t eb);
    send_vec(va, 1, "b2b_a");
    wait_out("b2b_a");
    recv_vec(ea, 1'b0, "b2b_a");
    send_vec(vb, 1, "b2b_b");
    wait_out("b2b_b");
    recv_vec(eb, 1'b1, "b2b_b");
  endtask

  task automatic test_n4();
    logic [7:0] vin [4];
    logic [7:0] vexp [4];
    int         cyc;
    vin  = '{8'd1, 8'd2, 8'd3, 8'd4};
    vexp = '{8'd10, 8'd7, 8'd15, 8'd6};
    mod4     = 8'd17;
    omegas4  = {8'd4, 8'd1};
    out_ready4 = 1'b1;
    for (int n = 0; n < 4; n++) begin
      int   guard;
      logic acc;
      guard     = 0;
      in_data4  = vin[n];
      in_valid4 = 1'b1;
      do begin
        acc = in_ready4;
        tick();
        guard++;
      end while (!acc && guard < 200);
      if (!acc) begin
        chk_cnt++;
        $display("FAIL n4 send timeout at beat %0d", n);
      end
    end
    in_valid4 = 1'b0;
    cyc = 0;
    while (!out_valid4 && cyc < 200) begin
      tick();
      cyc++;
    end
    chk_cnt++;
    if (cyc !== 8) $display("FAIL n4 latency: got %0d cycles, expected 8", cyc);
    else pass_cnt++;
    for (int n = 0; n < 4; n++) begin
      chk_cnt++;
      if (out_valid4 !== 1'b1 || out_data4 !== vexp[n])
        $display("FAIL n4 data[%0d]: got %0d (vld %b), expected %0d", n, out_data4, out_valid4, vexp[n]);
      else pass_cnt++;
      chk_cnt++;
      if (out_last4 !== (n == 3)) $display("FAIL n4 last[%0d]: got %b, expected %b", n, out_last4, (n == 3));
      else pass_cnt++;
      tick();
    end
    chk_cnt++;
    if (busy4 !== 1'b0 || in_ready4 !== 1'b1)
      $display("FAIL n4 idle: got busy=%b rdy=%b, expected 0/1", busy4, in_ready4);
    else pass_cnt++;
    out_ready4 = 1'b0;
  endtask

  initial begin
    vec_t v_delta, e_delta, v_ones, e_ones, v_big, e_12, v_12;
    v_delta = '{8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    e_delta = '{8'd1, 8'd2, 8'd4, 8'd8, 8'd16, 8'd15, 8'd13, 8'd9};
    v_ones  = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
    e_ones  = '{8'd8, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    v_big   = '{8'd18, 8'd19, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    v_12    = '{8'd1, 8'd2, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    e_12    = '{8'd3, 8'd5, 8'd9, 8'd0, 8'd16, 8'd14, 8'd10, 8'd2};

    in_data    = 8'd0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    in_data4   = 8'd0;
    in_valid4  = 1'b0;
    out_ready4 = 1'b0;
    mod4       = 8'd17;
    omegas4    = {8'd4, 8'd1};
    set_tw17();

    test_reset();
    test_n4();
    test_impulse(v_delta, e_delta);
    test_all_ones(v_ones, e_ones);
    test_mod_change(v_big, e_12);
    test_reset_mid(v_delta, e_delta);
    test_back_to_back(v_delta, e_delta, v_12, e_12);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
